// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state for misaligned redirect targets.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT = 3'd4
`endif
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter, pending redirect target and discard flag for the fetch FSM.
// A redirect that lands while a request is outstanding is parked until the stale response drains.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  fetch_state_e state,
    input  logic         rvalid,
    input  logic         instr_ready,
    input  logic         redirect,
    input  logic [31:0]  target,
    output logic [31:0]  pc,
    output logic         discard
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        disc_q, disc_d;

    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        disc_d = disc_q;
        case (state)
            IDLE: if (redirect) pc_d = target;
            REQ: begin
                if (redirect) begin
                    disc_d = 1'b1;
                    pend_d = target;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // a response arriving with the redirect is simply dropped
                    if (rvalid) begin
                        pc_d   = target;
                        disc_d = 1'b0;
                    end else begin
                        disc_d = 1'b1;
                        pend_d = target;
                    end
                end else if (rvalid && disc_q) begin
                    pc_d   = pend_q;
                    disc_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect)         pc_d = target;
                else if (instr_ready) pc_d = pc_q + PC_INC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_PC;
            pend_q <= RESET_PC;
            disc_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            disc_q <= disc_d;
        end
    end

    assign pc      = pc_q;
    assign discard = disc_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: one-outstanding imem requests, single-entry instruction buffer to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets into a sticky FAULT state.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ipc_q, ipc_d;
    logic [31:0]  p4_q, p4_d;
    logic [31:0]  fetch_pc;
    logic [31:0]  target;
    logic         discard;
    logic         misalign;
    logic         redir_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00) && (state_q != FAULT);
    assign target   = redirect_pc;
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign misalign   = 1'b0;
    assign target     = {redirect_pc[31:2], 2'b00};
`endif
    assign redir_ok = redirect && !misalign;

    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state_q),
        .rvalid      (imem_rvalid),
        .instr_ready (instr_ready),
        .redirect    (redir_ok),
        .target      (target),
        .pc          (fetch_pc),
        .discard     (discard)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        p4_d    = p4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) state_d = (redir_ok || discard) ? REQ : HOLD;
            end
            HOLD: begin
                if (redir_ok || instr_ready) state_d = REQ;
            end
            default: ;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign) begin
            state_d = FAULT;
            fault_d = 1'b1;
        end
`endif
        // buffer only loads on the WAIT->HOLD transition so decode sees stable fields
        if (state_q == WAIT && state_d == HOLD) begin
            instr_d = imem_rdata;
            ipc_d   = fetch_pc;
            p4_d    = fetch_pc + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
            p4_q    <= RESET_PC + PC_INC;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            p4_q    <= p4_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fault_q <= 1'b0;
        else          fault_q <= fault_d;
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = fetch_pc;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign pc          = ipc_q;
    assign pc_plus4    = p4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table for the basic handshake/redirect paths, directed
// corner sequences, then randomized traffic checked against an instruction-stream model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_fault (fetch_fault)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rd, input logic rdy,
                         input logic rdr, input logic [31:0] rpc);
        imem_rvalid = rv;
        imem_rdata  = rd;
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req"},   imem_req, 0);
        chk({tag, " addr"},  imem_addr, 32'h0);
        chk({tag, " vld"},   instr_valid, 0);
        chk({tag, " instr"}, instr, 32'h0000_0013);
        chk({tag, " pc"},    pc, 32'h0);
        chk({tag, " pc4"},   pc_plus4, 32'h4);
        chk({tag, " fault"}, fetch_fault, 0);
    endtask

    function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic rdr, input logic [31:0] rpc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_vld,
                                input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.rd = rd; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    // memory image for the random phase: any address-dependent scramble will do
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc, maddr, p_instr, p_pc;
        logic        pend, pv;
        int          cnt, delivered;

        vecs[0]  = mk(0, 0,            0, 0, 0,      1, 32'h0,   0, 32'h13,       32'h0);
        vecs[1]  = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'h13,       32'h0);
        vecs[2]  = mk(1, 32'hFFC4A303, 1, 0, 0,      0, 0,       1, 32'hFFC4A303, 32'h0);
        vecs[3]  = mk(0, 0,            1, 0, 0,      1, 32'h4,   0, 32'hFFC4A303, 32'h0);
        vecs[4]  = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'hFFC4A303, 32'h0);
        vecs[5]  = mk(0, 0,            0, 1, 32'h100,0, 0,       0, 32'hFFC4A303, 32'h0);
        vecs[6]  = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'hFFC4A303, 32'h0);
        vecs[7]  = mk(1, 32'h0062E233, 0, 0, 0,      1, 32'h100, 0, 32'hFFC4A303, 32'h0);
        vecs[8]  = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'hFFC4A303, 32'h0);
        vecs[9]  = mk(1, 32'h00000093, 1, 0, 0,      0, 0,       1, 32'h00000093, 32'h100);
        vecs[10] = mk(0, 0,            1, 1, 32'h8,  1, 32'h8,   0, 32'h00000093, 32'h100);
        vecs[11] = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'h00000093, 32'h100);
        vecs[12] = mk(1, 32'hFE420AE3, 0, 0, 0,      0, 0,       1, 32'hFE420AE3, 32'h8);
        vecs[13] = mk(0, 0,            1, 1, 32'h0,  1, 32'h0,   0, 32'hFE420AE3, 32'h8);
        vecs[14] = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'hFE420AE3, 32'h8);
        vecs[15] = mk(1, 32'h00A00113, 0, 0, 0,      0, 0,       1, 32'h00A00113, 32'h0);
        vecs[16] = mk(0, 0,            0, 1, 32'h40, 1, 32'h40,  0, 32'h00A00113, 32'h0);
        vecs[17] = mk(0, 0,            0, 1, 32'h80, 0, 0,       0, 32'h00A00113, 32'h0);
        vecs[18] = mk(1, 32'hDEADBEEF, 0, 1, 32'hC0, 1, 32'hC0,  0, 32'h00A00113, 32'h0);
        vecs[19] = mk(1, 32'h0BADF00D, 0, 0, 0,      0, 0,       0, 32'h00A00113, 32'h0);
        vecs[20] = mk(1, 32'h13579BDF, 0, 0, 0,      0, 0,       1, 32'h13579BDF, 32'hC0);
        vecs[21] = mk(0, 0,            1, 0, 0,      1, 32'hC4,  0, 32'h13579BDF, 32'hC0);
        vecs[22] = mk(0, 0,            0, 1, 32'h200,0, 0,       0, 32'h13579BDF, 32'hC0);
        vecs[23] = mk(0, 0,            0, 1, 32'h300,0, 0,       0, 32'h13579BDF, 32'hC0);
        vecs[24] = mk(1, 32'h11111111, 0, 0, 0,      1, 32'h300, 0, 32'h13579BDF, 32'hC0);
        vecs[25] = mk(0, 0,            0, 0, 0,      0, 0,       0, 32'h13579BDF, 32'hC0);
        vecs[26] = mk(1, 32'h22222222, 0, 0, 0,      0, 0,       1, 32'h22222222, 32'h300);

        // reset state, then release away from the edge
        cyc(); cyc();
        chk_reset("rst");
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rv, vecs[i].rd, vecs[i].rdy, vecs[i].rdr, vecs[i].rpc);
            cyc();
            chk($sformatf("v%0d req", i),   imem_req, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d vld", i),   instr_valid, vecs[i].e_vld);
            chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
            chk($sformatf("v%0d pc", i),    pc, vecs[i].e_pc);
            chk($sformatf("v%0d pc4", i),   pc_plus4, vecs[i].e_pc + 32'd4);
        end
        drive(0, 0, 0, 0, 0);

        // decode stalls five cycles: buffer stays put, no new fetch
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall vld", instr_valid, 1);
            chk("stall instr", instr, 32'h22222222);
            chk("stall pc", pc, 32'h300);
            chk("stall req", imem_req, 0);
        end
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("stall next req", imem_req, 1);
        chk("stall next addr", imem_addr, 32'h304);
        cyc();
        chk("single fetch a", imem_req, 0);
        cyc();
        chk("single fetch b", imem_req, 0);

        // PC wrap at the top of the address space
        drive(1, 32'h00400093, 0, 0, 0); cyc();
        chk("wrap hold pc", pc, 32'h304);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC); cyc();
        chk("wrap req addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0); cyc();
        drive(1, 32'h00108093, 0, 0, 0); cyc();
        chk("wrap pc", pc, 32'hFFFF_FFFC);
        chk("wrap pc4", pc_plus4, 32'h0);
        drive(0, 0, 1, 0, 0); cyc();
        chk("wrap next req", imem_req, 1);
        chk("wrap next addr", imem_addr, 32'h0);
        drive(0, 0, 0, 0, 0); cyc();
        drive(1, 32'h00208113, 0, 0, 0); cyc();
        chk("wrap land pc", pc, 32'h0);

        // misaligned redirect target
        drive(0, 0, 0, 1, 32'h0000_0102); cyc();
        drive(0, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis fault", fetch_fault, 1);
        chk("mis vld", instr_valid, 0);
        chk("mis req", imem_req, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 32'h40);
            cyc();
            chk("fault req", imem_req, 0);
            chk("fault sticky", fetch_fault, 1);
            chk("fault vld", instr_valid, 0);
        end
        drive(0, 0, 0, 0, 0);
`else
        chk("mis req", imem_req, 1);
        chk("mis addr", imem_addr, 32'h100);
        chk("mis fault", fetch_fault, 0);
`endif

        // asynchronous reset mid-operation, late rvalid after release ignored
        cyc();
        #2 reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        cyc();
        reset_n = 1'b1;
        drive(1, 32'hAAAA5555, 0, 0, 0); cyc();
        chk("late rv req", imem_req, 1);
        chk("late rv addr", imem_addr, 32'h0);
        chk("late rv vld", instr_valid, 0);
        drive(1, 32'h5555AAAA, 0, 0, 0); cyc();
        chk("junk in req vld", instr_valid, 0);
        drive(1, 32'h00300193, 0, 0, 0); cyc();
        chk("post rst vld", instr_valid, 1);
        chk("post rst instr", instr, 32'h00300193);
        drive(0, 0, 0, 0, 0);

        // random traffic vs instruction-stream model
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        exp_pc = 32'h0; pend = 1'b0; cnt = 0; pv = 1'b0; maddr = 32'h0;
        p_instr = 32'h0; p_pc = 32'h0; delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            if (pv) begin
                chk("rnd hold vld", instr_valid, 1);
                chk("rnd hold instr", instr, p_instr);
                chk("rnd hold pc", pc, p_pc);
            end
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(maddr);
                    pend = 1'b0;
                end else cnt--;
            end else if ($urandom_range(7) == 0) imem_rvalid = 1'b1;
            if (imem_req) begin
                chk("rnd one outstanding", pend, 0);
                chk("rnd addr align", imem_addr[1:0], 0);
                pend  = 1'b1;
                maddr = imem_addr;
                cnt   = $urandom_range(2);
            end
            instr_ready = 1'($urandom_range(1));
            redirect    = ($urandom_range(15) == 0);
            redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc[1:0] = 2'b00;
`endif
            if (instr_valid && instr_ready) begin
                chk("rnd pc", pc, exp_pc);
                chk("rnd instr", instr, word(exp_pc));
                chk("rnd pc4", pc_plus4, exp_pc + 32'd4);
                delivered++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            pv = instr_valid && !instr_ready && !redirect;
            p_instr = instr;
            p_pc = pc;
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("rnd throughput", 32'(delivered > 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
